mod_n_counter: RTL and testbench

Parametrised synchronous modulo-N counter that generalises the team's fixed 3-bit mod-7 counter. It supports a compile-time width and modulus, up/down counting, a clock enable and a synchronous parallel load. It produces a combinational terminal-count output for cascading and an optional sticky wrap flag. It sits in the lab's counter/timer library as the base block for dividers, prescalers and sequence generators.

---
 rtl/mod_n_counter.sv | 94 +++++++++
 tb/tb_mod_n_counter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mod_n_counter.sv
// mod_n_counter: parametrised modulo-N up/down counter with clock enable, synchronous load,
// combinational terminal count and registered wrap pulse. Define MOD_N_COUNTER_WRAP_STICKY_EN for the sticky wrap flag.
module mod_n_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_wrap,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             wrap_sticky
);
    generate
        if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
            $fatal(1, "mod_n_counter: WIDTH must be in 1..16");
        end
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $fatal(1, "mod_n_counter: MODULUS must be in 2..2**WIDTH");
        end
    endgenerate

    // One extra bit so MODULUS itself is representable when MODULUS == 2**WIDTH.
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] TOP_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH:0]   w_count_ext;
    logic [WIDTH:0]   w_load_ext;
    logic [WIDTH:0]   w_sum;
    logic             w_at_term;
    logic             w_unused;

    assign w_count_ext = {1'b0, r_count};
    assign w_load_ext  = {1'b0, load_val};
    assign w_at_term   = up_dn ? (w_count_ext == TOP_EXT) : (w_count_ext == '0);
    assign tc          = en & ~load & ~rst & w_at_term;

    always_comb begin
        w_sum = w_count_ext;
        if (load) begin
            w_sum = (w_load_ext < MOD_EXT) ? w_load_ext : '0;
        end else if (en) begin
            if (up_dn) begin
                w_sum = (w_count_ext == TOP_EXT) ? '0 : w_count_ext + ONE_EXT;
            end else begin
                w_sum = (w_count_ext == '0) ? TOP_EXT : w_count_ext - ONE_EXT;
            end
        end
    end

    // A wrap is exactly an enabled, non-loading step taken from the terminal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_sum[WIDTH-1:0];
            r_wrap  <= tc;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;

`ifdef MOD_N_COUNTER_WRAP_STICKY_EN
    logic r_wrap_sticky;

    // Set has priority over clear so a coincident wrap is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap_sticky <= 1'b0;
        end else if (r_wrap) begin
            r_wrap_sticky <= 1'b1;
        end else if (clr_wrap) begin
            r_wrap_sticky <= 1'b0;
        end
    end

    assign wrap_sticky = r_wrap_sticky;
`else
    assign wrap_sticky = 1'b0;
`endif

    assign w_unused = w_sum[WIDTH] ^ clr_wrap;

endmodule

// File: tb/tb_mod_n_counter.sv
// Bench for mod_n_counter: mod-7 and mod-10 instances share directed and random stimulus checked
// against an arithmetic model; a cascaded mod-10 pair is checked for BCD 00..99 counting.
module tb_mod_n_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;
    logic       load = 1'b0;
    logic       clr_wrap = 1'b0;
    logic [3:0] lv = 4'd0;

    logic [2:0] cnt7;
    logic       tc7, wr7, st7;
    logic [3:0] cnt10;
    logic       tc10, wr10, st10;

    logic       c_rst = 1'b1;
    logic       c_en = 1'b0;
    logic [3:0] c0_cnt, c1_cnt;
    logic       c0_tc, c0_wr, c0_st, c1_tc, c1_wr, c1_st;

    always #5 clk = ~clk;

    mod_n_counter #(.WIDTH(3), .MODULUS(7)) u7 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv[2:0]),
        .clr_wrap(clr_wrap), .count(cnt7), .tc(tc7), .wrap(wr7), .wrap_sticky(st7)
    );

    mod_n_counter #(.WIDTH(4), .MODULUS(10)) u10 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv),
        .clr_wrap(clr_wrap), .count(cnt10), .tc(tc10), .wrap(wr10), .wrap_sticky(st10)
    );

    mod_n_counter #(.WIDTH(4), .MODULUS(10)) u_c0 (
        .clk(clk), .rst(c_rst), .en(c_en), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
        .clr_wrap(1'b0), .count(c0_cnt), .tc(c0_tc), .wrap(c0_wr), .wrap_sticky(c0_st)
    );

    mod_n_counter #(.WIDTH(4), .MODULUS(10)) u_c1 (
        .clk(clk), .rst(c_rst), .en(c0_tc), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
        .clr_wrap(1'b0), .count(c1_cnt), .tc(c1_tc), .wrap(c1_wr), .wrap_sticky(c1_st)
    );

    int mods[2] = '{7, 10};
    int m_cnt[2] = '{0, 0};
    int m_wrap[2] = '{0, 0};
    int m_st[2] = '{0, 0};
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int lv_of(input int i);
        return (i == 0) ? int'(lv[2:0]) : int'(lv);
    endfunction

    // Terminal count from the rules: enabled, not loading, not in reset, sitting at the terminal value.
    function automatic int exp_tc(input int i);
        int term;
        term = up_dn ? mods[i] - 1 : 0;
        return (en && !load && !rst && m_cnt[i] == term) ? 1 : 0;
    endfunction

    task automatic cyc(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] v, input logic c);
        int t[2];
        int oc, nc;
        @(negedge clk);
        rst = r; en = e; up_dn = u; load = l; lv = v; clr_wrap = c;
        #1;
        for (int i = 0; i < 2; i++) t[i] = exp_tc(i);
        chk("tc7", 32'(tc7), 32'(t[0]));
        chk("tc10", 32'(tc10), 32'(t[1]));
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_cnt[i] = 0; m_wrap[i] = 0; m_st[i] = 0;
            end else begin
`ifdef MOD_N_COUNTER_WRAP_STICKY_EN
                if (m_wrap[i] != 0) m_st[i] = 1;
                else if (c) m_st[i] = 0;
`else
                m_st[i] = 0;
`endif
                oc = m_cnt[i];
                nc = oc;
                if (l) nc = (lv_of(i) < mods[i]) ? lv_of(i) : 0;
                else if (e) nc = u ? (oc + 1) % mods[i] : (oc + mods[i] - 1) % mods[i];
                // a wrap is an enabled step whose result crossed the modulus boundary
                m_wrap[i] = (!l && e && (u ? nc < oc : nc > oc)) ? 1 : 0;
                m_cnt[i] = nc;
            end
        end
        #1;
        chk("count7", 32'(cnt7), 32'(m_cnt[0]));
        chk("wrap7", 32'(wr7), 32'(m_wrap[0]));
        chk("sticky7", 32'(st7), 32'(m_st[0]));
        chk("count10", 32'(cnt10), 32'(m_cnt[1]));
        chk("wrap10", 32'(wr10), 32'(m_wrap[1]));
        chk("sticky10", 32'(st10), 32'(m_st[1]));
    endtask

    initial begin
        int w1;
        // reset with en=1, up_dn=0 at count 0: tc must still be low
        repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        repeat (16) cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        repeat (9) cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        // loads: in range, out of range, load beats en at the terminal value
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd12, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        // clr_wrap during the wrap pulse, then on its own
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'($urandom), 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        // direction reversal at the up terminal value
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        repeat (400) cyc(1'(($urandom % 40) == 0), 1'(($urandom % 4) != 0), 1'($urandom),
                         1'(($urandom % 6) == 0), 4'($urandom), 1'(($urandom % 5) == 0));

        // cascaded BCD pair
        @(negedge clk);
        chk("bcd_reset", 32'(int'(c1_cnt) * 10 + int'(c0_cnt)), 32'(0));
        c_rst = 1'b0;
        c_en = 1'b1;
        w1 = 0;
        for (int k = 1; k <= 101; k++) begin
            @(posedge clk);
            #1;
            chk("bcd", 32'(int'(c1_cnt) * 10 + int'(c0_cnt)), 32'(k % 100));
            if (c1_wr) w1++;
        end
        chk("bcd_stage1_wraps", 32'(w1), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
